// File: rtl/jtag_tap_ir.sv
// jtag_tap_ir: IEEE 1149.1 TAP controller with instruction register, BYPASS,
// NUM_DR user data-register selects and an optional IDCODE register.
// Optional feature macro: JTAG_TAP_IDCODE_EN (IDCODE register, decode and
// IDCODE as the reset instruction; BYPASS otherwise).
module jtag_tap_ir #(
  parameter int unsigned IR_W       = 4,
  parameter int unsigned NUM_DR     = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic              clk,
  input  logic              trst,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_en,
  output logic [3:0]        tstate,
  output logic [IR_W-1:0]   ir_out,
  output logic [NUM_DR-1:0] dr_sel,
  output logic              capture_dr,
  output logic              shift_dr,
  output logic              update_dr,
  input  logic [NUM_DR-1:0] user_tdo
);

  typedef enum logic [3:0] {
    ST_TLR   = 4'd0,
    ST_IDLE  = 4'd1,
    ST_SELDR = 4'd2,
    ST_CAPDR = 4'd3,
    ST_SHDR  = 4'd4,
    ST_EX1DR = 4'd5,
    ST_PDR   = 4'd6,
    ST_EX2DR = 4'd7,
    ST_UPDR  = 4'd8,
    ST_SELIR = 4'd9,
    ST_CAPIR = 4'd10,
    ST_SHIR  = 4'd11,
    ST_EX1IR = 4'd12,
    ST_PIR   = 4'd13,
    ST_EX2IR = 4'd14,
    ST_UPIR  = 4'd15
  } tap_state_e;

  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);
  localparam logic [IR_W-1:0] IR_BYPASS  = '1;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(1);
  localparam logic [IR_W-1:0] IR_RESET   = IR_IDCODE;
`else
  localparam logic [IR_W-1:0] IR_RESET   = IR_BYPASS;
`endif

  tap_state_e        state_q, state_d;
  logic [IR_W-1:0]   ir_sr_q, ir_sr_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              bypass_q, bypass_d;
  logic              tdo_q, tdo_d;
  logic              tdo_en_q, tdo_en_d;
  logic [IR_W-1:0]   ir_out_c;
  logic [NUM_DR-1:0] dr_sel_c;
  logic              dr_tdo_c;

  // TAP next-state: standard 16-state walk driven by tms
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_TLR:   state_d = tms ? ST_TLR   : ST_IDLE;
      ST_IDLE:  state_d = tms ? ST_SELDR : ST_IDLE;
      ST_SELDR: state_d = tms ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: state_d = tms ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  state_d = tms ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: state_d = tms ? ST_UPDR  : ST_PDR;
      ST_PDR:   state_d = tms ? ST_EX2DR : ST_PDR;
      ST_EX2DR: state_d = tms ? ST_UPDR  : ST_SHDR;
      ST_UPDR:  state_d = tms ? ST_SELDR : ST_IDLE;
      ST_SELIR: state_d = tms ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: state_d = tms ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  state_d = tms ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: state_d = tms ? ST_UPIR  : ST_PIR;
      ST_PIR:   state_d = tms ? ST_EX2IR : ST_PIR;
      ST_EX2IR: state_d = tms ? ST_UPIR  : ST_SHIR;
      ST_UPIR:  state_d = tms ? ST_SELDR : ST_IDLE;
      default:  state_d = ST_TLR;
    endcase
  end

  // IR and BYPASS shift paths, advanced on rising TCK
  always_comb begin
    ir_sr_d  = ir_sr_q;
    bypass_d = bypass_q;
    case (state_q)
      ST_CAPIR: ir_sr_d  = IR_CAPTURE;
      ST_SHIR:  ir_sr_d  = {tdi, ir_sr_q[IR_W-1:1]};
      ST_CAPDR: bypass_d = 1'b0;
      ST_SHDR:  bypass_d = tdi;
      default:  ;
    endcase
  end

  // Rising-edge state: TAP state and shift registers
  always_ff @(posedge clk or negedge trst) begin
    if (!trst) begin
      state_q  <= ST_TLR;
      ir_sr_q  <= IR_CAPTURE;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_sr_q  <= ir_sr_d;
      bypass_q <= bypass_d;
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_q, idcode_d;
  logic        idcode_sel_c;

  // IDCODE shift path; bit 0 is always 1 as 1149.1 requires
  always_comb begin
    idcode_d = idcode_q;
    if (state_q == ST_CAPDR)     idcode_d = {IDCODE_VAL[31:1], 1'b1};
    else if (state_q == ST_SHDR) idcode_d = {tdi, idcode_q[31:1]};
  end

  // IDCODE register
  always_ff @(posedge clk or negedge trst) begin
    if (!trst) idcode_q <= '0;
    else       idcode_q <= idcode_d;
  end

  assign idcode_sel_c = (ir_out_c == IR_IDCODE);
`else
  logic unused_idcode;
  assign unused_idcode = ^IDCODE_VAL;
`endif

  // Active instruction: TLR overrides immediately so the reset instruction
  // appears at the rising edge that enters TLR, not half a cycle later
  assign ir_out_c = (state_q == ST_TLR) ? IR_RESET : ir_q;

  // One-hot user DR decode; unlisted codes fall through to BYPASS
  always_comb begin
    dr_sel_c = '0;
    for (int k = 0; k < int'(NUM_DR); k++) begin
      if (ir_out_c == IR_W'(k + 2)) dr_sel_c[k] = 1'b1;
    end
  end

  // Serial output of the DR currently selected by the instruction
  always_comb begin
    dr_tdo_c = bypass_q;
    if (|dr_sel_c) dr_tdo_c = |(user_tdo & dr_sel_c);
`ifdef JTAG_TAP_IDCODE_EN
    else if (idcode_sel_c) dr_tdo_c = idcode_q[0];
`endif
  end

  // Falling-edge updates: instruction latch and tdo path
  always_comb begin
    ir_d = ir_q;
    if (state_q == ST_UPIR)     ir_d = ir_sr_q;
    else if (state_q == ST_TLR) ir_d = IR_RESET;
    tdo_d = tdo_q;
    if (state_q == ST_SHIR)     tdo_d = ir_sr_q[0];
    else if (state_q == ST_SHDR) tdo_d = dr_tdo_c;
    tdo_en_d = (state_q == ST_SHIR) || (state_q == ST_SHDR);
  end

  // Falling-edge registers
  always_ff @(negedge clk or negedge trst) begin
    if (!trst) begin
      ir_q     <= IR_RESET;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tstate     = state_q;
  assign ir_out     = ir_out_c;
  assign dr_sel     = dr_sel_c;
  assign tdo        = tdo_q;
  assign tdo_en     = tdo_en_q;
  assign capture_dr = (state_q == ST_CAPDR) && (|dr_sel_c);
  assign shift_dr   = (state_q == ST_SHDR)  && (|dr_sel_c);
  assign update_dr  = (state_q == ST_UPDR)  && (|dr_sel_c);

endmodule

// File: tb/tb_jtag_tap_ir.sv
// tb_jtag_tap_ir: directed bench for jtag_tap_ir with a table-driven TAP model.
module tb_jtag_tap_ir;
  localparam int IR_W   = 4;
  localparam int NUM_DR = 4;
  localparam logic [31:0] IDC = 32'h1000_0001;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0] RST_IR = 4'h1;
`else
  localparam logic [3:0] RST_IR = 4'hF;
`endif

  localparam int S_TLR = 0, S_IDLE = 1, S_SELDR = 2, S_CAPDR = 3, S_SHDR = 4,
                 S_EX1DR = 5, S_PDR = 6, S_EX2DR = 7, S_UPDR = 8, S_SELIR = 9,
                 S_CAPIR = 10, S_SHIR = 11, S_EX1IR = 12, S_PIR = 13,
                 S_EX2IR = 14, S_UPIR = 15;

  logic clk = 1'b0;
  logic trst, tms, tdi;
  logic tdo, tdo_en;
  logic [3:0] tstate;
  logic [IR_W-1:0] ir_out;
  logic [NUM_DR-1:0] dr_sel, user_tdo;
  logic capture_dr, shift_dr, update_dr;

  jtag_tap_ir #(.IR_W(IR_W), .NUM_DR(NUM_DR), .IDCODE_VAL(IDC)) dut (
    .clk(clk), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .tstate(tstate), .ir_out(ir_out), .dr_sel(dr_sel), .capture_dr(capture_dr),
    .shift_dr(shift_dr), .update_dr(update_dr), .user_tdo(user_tdo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int upd_cnt = 0;

  // model state
  int nxt0[16];
  int nxt1[16];
  int m_st;
  logic [3:0] m_irsh, m_ir;
  logic m_byp, m_tdo, m_en;
  logic [31:0] m_idc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_sel(input logic [3:0] ir);
    int c;
    c = int'(ir);
    if (c >= 2 && c <= NUM_DR + 1) return 4'(1 << (c - 2));
    return 4'b0;
  endfunction

  function automatic bit m_is_idc(input logic [3:0] ir);
`ifdef JTAG_TAP_IDCODE_EN
    return ir == 4'h1;
`else
    return (ir == 4'hF) && 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_st = S_TLR; m_irsh = 4'h1; m_ir = RST_IR;
    m_tdo = 1'b0; m_en = 1'b0; m_byp = 1'b0; m_idc = '0;
  endtask

  task automatic m_pos();
    if (!trst) begin m_reset(); return; end
    if (m_st == S_CAPIR) m_irsh = 4'h1;
    if (m_st == S_SHIR)  m_irsh = {tdi, m_irsh[3:1]};
    if (m_st == S_CAPDR) begin m_byp = 1'b0; m_idc = IDC; end
    if (m_st == S_SHDR)  begin m_byp = tdi; m_idc = {tdi, m_idc[31:1]}; end
    m_st = tms ? nxt1[m_st] : nxt0[m_st];
    if (m_st == S_TLR) m_ir = RST_IR;
  endtask

  task automatic m_neg();
    logic [3:0] s;
    if (!trst) begin m_reset(); return; end
    if (m_st == S_UPIR) m_ir = m_irsh;
    if (m_st == S_TLR)  m_ir = RST_IR;
    m_en = (m_st == S_SHIR) || (m_st == S_SHDR);
    s = m_sel(m_ir);
    if (m_st == S_SHIR) m_tdo = m_irsh[0];
    else if (m_st == S_SHDR) begin
      if (s != 0)              m_tdo = user_tdo[int'(m_ir) - 2];
      else if (m_is_idc(m_ir)) m_tdo = m_idc[0];
      else                     m_tdo = m_byp;
    end
  endtask

  // compare DUT against model shortly after every clock edge
  always begin
    @(clk);
    #1;
    if (chk_en) begin
      chk("tstate", 32'(tstate), 32'(m_st));
      chk("ir_out", 32'(ir_out), 32'(m_ir));
      chk("dr_sel", 32'(dr_sel), 32'(m_sel(m_ir)));
      chk("capture_dr", 32'(capture_dr), 32'((m_st == S_CAPDR) && (m_sel(m_ir) != 0)));
      chk("shift_dr", 32'(shift_dr), 32'((m_st == S_SHDR) && (m_sel(m_ir) != 0)));
      chk("update_dr", 32'(update_dr), 32'((m_st == S_UPDR) && (m_sel(m_ir) != 0)));
      chk("tdo", 32'(tdo), 32'(m_tdo));
      chk("tdo_en", 32'(tdo_en), 32'(m_en));
    end
  end

  always @(posedge update_dr) upd_cnt++;

  task automatic tick(input logic t, input logic d);
    tms = t; tdi = d;
    @(posedge clk); m_pos();
    @(negedge clk); m_neg();
    #2;
  endtask

  // Idle -> Capture -> Shift n bits -> Update -> Idle; dout[i] is the i-th tdo bit
  task automatic scan(input bit is_ir, input int n, input logic [31:0] din,
                      input bit user_mode, output logic [31:0] dout, output logic sd);
    dout = '0; sd = 1'b0;
    tick(1'b1, 1'b0);
    if (is_ir) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    if (user_mode) user_tdo = 4'b1101;
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      sd = sd | shift_dr;
      if (user_mode) user_tdo = din[i] ? 4'b0010 : 4'b1101;
      tick(i == n - 1, din[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  logic [31:0] dout;
  logic sd;
  int upd_before;

  initial begin
    nxt0 = '{S_IDLE, S_IDLE, S_CAPDR, S_SHDR, S_SHDR, S_PDR, S_PDR, S_SHDR,
             S_IDLE, S_CAPIR, S_SHIR, S_SHIR, S_PIR, S_PIR, S_SHIR, S_IDLE};
    nxt1 = '{S_TLR, S_SELDR, S_SELIR, S_EX1DR, S_EX1DR, S_UPDR, S_EX2DR, S_UPDR,
             S_SELDR, S_TLR, S_EX1IR, S_EX1IR, S_UPIR, S_EX2IR, S_UPIR, S_SELDR};
    trst = 1'b0; tms = 1'b1; tdi = 1'b0; user_tdo = '0;
    m_reset();
    tick(1'b1, 1'b0);
    chk_en = 1'b1;
    tick(1'b1, 1'b0);
    trst = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("rst_tstate", 32'(tstate), 32'd0);
    chk("rst_ir_out", 32'(ir_out), 32'(RST_IR));
    chk("rst_tdo_en", 32'(tdo_en), 32'd0);
    chk("rst_dr_sel", 32'(dr_sel), 32'd0);

    // DR scan after reset: IDCODE stream or 1-bit bypass delay
    tick(1'b0, 1'b0);
    scan(1'b0, 32, 32'hFFFF_FFFF, 1'b0, dout, sd);
`ifdef JTAG_TAP_IDCODE_EN
    chk("idcode_stream", dout, 32'h1000_0001);
`else
    chk("reset_bypass_stream", dout, 32'hFFFF_FFFE);
`endif

    // BYPASS instruction
    scan(1'b1, 4, 32'hF, 1'b0, dout, sd);
    chk("ir_capture_bits", 32'(dout[3:0]), 32'h1);
    chk("ir_bypass", 32'(ir_out), 32'hF);
    chk("bypass_dr_sel", 32'(dr_sel), 32'h0);
    scan(1'b0, 9, 32'hA5, 1'b0, dout, sd);
    chk("bypass_stream", 32'(dout[8:0]), 32'h14A);
    chk("bypass_shift_dr", 32'(sd), 32'd0);

`ifndef JTAG_TAP_IDCODE_EN
    // code 1 without the IDCODE register acts as BYPASS
    scan(1'b1, 4, 32'h1, 1'b0, dout, sd);
    chk("ir_code1", 32'(ir_out), 32'h1);
    scan(1'b0, 9, 32'hA5, 1'b0, dout, sd);
    chk("code1_bypass_stream", 32'(dout[8:0]), 32'h14A);
`endif

    // user DR channel 1
    scan(1'b1, 4, 32'h3, 1'b0, dout, sd);
    chk("ir_user3", 32'(ir_out), 32'h3);
    chk("user3_dr_sel", 32'(dr_sel), 32'b0010);
    scan(1'b0, 9, 32'hA5, 1'b1, dout, sd);
    chk("user_tdo_stream", 32'(dout[8:0]), 32'h14A);
    chk("user_shift_dr", 32'(sd), 32'd1);
    user_tdo = '0;

    // Shift-IR capture bits then five tms=1 edges to TLR
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    dout = '0;
    for (int i = 0; i < 4; i++) begin
      dout[i] = tdo;
      tick(1'b0, 1'b0);
    end
    chk("shir_first_bits", 32'(dout[3:0]), 32'h1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk("tms5_tstate", 32'(tstate), 32'd0);
    chk("tms5_ir_out", 32'(ir_out), 32'(RST_IR));

    // trst in the middle of Shift-DR with a user instruction active
    tick(1'b0, 1'b0);
    scan(1'b1, 4, 32'h3, 1'b0, dout, sd);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b1);
    chk("pre_trst_shift_dr", 32'(shift_dr), 32'd1);
    upd_before = upd_cnt;
    trst = 1'b0;
    m_reset();
    #1;
    chk("trst_tstate", 32'(tstate), 32'd0);
    chk("trst_tdo_en", 32'(tdo_en), 32'd0);
    chk("trst_tdo", 32'(tdo), 32'd0);
    chk("trst_ir_out", 32'(ir_out), 32'(RST_IR));
    chk("trst_dr_sel", 32'(dr_sel), 32'd0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    trst = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("trst_no_update", 32'(upd_cnt), 32'(upd_before));
    chk("post_trst_ir_out", 32'(ir_out), 32'(RST_IR));
    chk("post_trst_tstate", 32'(tstate), 32'd1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
